operand_skewer: RTL and testbench

- Upstream stage of the systolic array.
- Accepts one un-skewed operand vector per beat: ARRAY_SIZE lanes of DATA_WIDTH each, one row of matrix A or one column of B.
- Applies the diagonal skew (lane i delayed i cycles) and drives the array's edge data.
- Generates the array's per-operand first/last markers and the compute_enable window; instantiated once for inputs and once for weights.

---
 rtl/operand_skewer_pkg.sv | 15 +
 rtl/operand_skewer_skew_delay_line.sv | 26 ++
 rtl/operand_skewer.sv | 132 +++++++++++++
 tb/tb_operand_skewer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_skewer_pkg.sv
// Shared definitions for the operand skewer and its delay lines.
package operand_skewer_pkg;

  localparam int DEF_ARRAY_SIZE = 4;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_K_WIDTH    = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2,
    DONE   = 2'd3
  } skewer_state_t;

endpackage

// File: rtl/operand_skewer_skew_delay_line.sv
// Fixed-depth shift register for one skew lane; output is the last stage.
module skew_delay_line #(
  parameter int DEPTH      = 1,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  clr_n,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] stage [DEPTH];

  // Shift one stage per clock; clr_n low zeroes every stage.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      for (int j = 0; j < DEPTH; j++) stage[j] <= '0;
    end else begin
      stage[0] <= din;
      for (int j = 1; j < DEPTH; j++) stage[j] <= stage[j-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/operand_skewer.sv
// Operand skewer: diagonally skews one operand vector per beat for the
// systolic array edge and generates first/last markers and compute_enable.
// Optional feature macro: OPERAND_SKEWER_LANE_MASK_EN (adds lane_mask port).
//
// state  | meaning
// IDLE   | waiting for start, delay lines hold zeros
// STREAM | accepting k_len beats (bubbles insert zero vectors)
// FLUSH  | ARRAY_SIZE-1 cycles pushing zeros until last lane drains
// DONE   | tile complete, done pulses on the following cycle
module operand_skewer
  import operand_skewer_pkg::*;
#(
  parameter int ARRAY_SIZE = DEF_ARRAY_SIZE,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int K_WIDTH    = DEF_K_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [K_WIDTH-1:0]               k_len,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] in_data,
`ifdef OPERAND_SKEWER_LANE_MASK_EN
  input  logic [ARRAY_SIZE-1:0]            lane_mask,
`endif
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0] out_data,
  output logic                             out_valid,
  output logic                             out_first,
  output logic                             out_last,
  output logic                             busy,
  output logic                             done
);

  localparam int FW = $clog2(ARRAY_SIZE + 1);
  localparam logic [FW-1:0]      FLUSH_LAST = FW'(ARRAY_SIZE - 2);
  localparam logic [FW-1:0]      F_ONE      = FW'(1);
  localparam logic [K_WIDTH-1:0] K_ONE      = K_WIDTH'(1);

  skewer_state_t         state;
  logic [K_WIDTH-1:0]    k_len_q;
  logic [K_WIDTH-1:0]    beat_cnt;
  logic [FW-1:0]         flush_cnt;
  logic [ARRAY_SIZE-1:0] last_pipe;
  logic [ARRAY_SIZE-1:0] lane_en;
  logic                  accept;
  logic                  last_beat;

  assign in_ready  = (state == STREAM);
  assign busy      = (state != IDLE);
  assign accept    = in_valid && (state == STREAM);
  // k_len_q is never zero in STREAM, so the subtraction cannot wrap there.
  assign last_beat = (beat_cnt == (k_len_q - K_ONE));
  assign out_last  = last_pipe[ARRAY_SIZE-1];

`ifdef OPERAND_SKEWER_LANE_MASK_EN
  logic [ARRAY_SIZE-1:0] mask_q;
  assign lane_en = mask_q;
`else
  assign lane_en = '1;
`endif

  // Sequencer FSM with counters and marker delay; markers are registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      k_len_q   <= '0;
      beat_cnt  <= '0;
      flush_cnt <= '0;
      last_pipe <= '0;
      out_first <= 1'b0;
      out_valid <= 1'b0;
      done      <= 1'b0;
`ifdef OPERAND_SKEWER_LANE_MASK_EN
      mask_q    <= '0;
`endif
    end else begin
      out_first <= accept && (beat_cnt == '0);
      // The last-beat flag travels with the data to the far lane.
      last_pipe <= (last_pipe << 1) | ARRAY_SIZE'(accept && last_beat);
      done      <= (state == DONE);
      if (accept && (beat_cnt == '0)) out_valid <= 1'b1;
      else if (out_last)              out_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            k_len_q  <= k_len;
            beat_cnt <= '0;
`ifdef OPERAND_SKEWER_LANE_MASK_EN
            mask_q   <= lane_mask;
`endif
            state    <= (k_len == '0) ? DONE : STREAM;
          end
        end
        STREAM: begin
          if (accept) begin
            if (last_beat) begin
              beat_cnt  <= '0;
              flush_cnt <= '0;
              state     <= (ARRAY_SIZE > 1) ? FLUSH : DONE;
            end else begin
              beat_cnt <= beat_cnt + K_ONE;
            end
          end
        end
        FLUSH: begin
          if (flush_cnt == FLUSH_LAST) state <= DONE;
          else                         flush_cnt <= flush_cnt + F_ONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
    logic [DATA_WIDTH-1:0] lane_in;
    // Non-accepted cycles (bubbles, flush, idle) push zeros to keep lanes aligned.
    assign lane_in = (accept && lane_en[i]) ? in_data[i*DATA_WIDTH +: DATA_WIDTH] : '0;
    skew_delay_line #(
      .DEPTH      (i + 1),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_delay (
      .clk   (clk),
      .clr_n (rst_n),
      .din   (lane_in),
      .dout  (out_data[i*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule

// File: tb/tb_operand_skewer.sv
// Directed self-checking bench for operand_skewer (4 lanes x 16 bits).
module tb_operand_skewer;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int KW = 16;

  logic            clk = 1'b0;
  logic            rst_n, start, in_valid;
  logic [KW-1:0]   k_len;
  logic [N*DW-1:0] in_data, out_data;
  logic            in_ready, out_valid, out_first, out_last, busy, done;
`ifdef OPERAND_SKEWER_LANE_MASK_EN
  logic [N-1:0]    lane_mask;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  operand_skewer #(.ARRAY_SIZE(N), .DATA_WIDTH(DW), .K_WIDTH(KW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .k_len     (k_len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
`ifdef OPERAND_SKEWER_LANE_MASK_EN
    .lane_mask (lane_mask),
`endif
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_first (out_first),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  function automatic logic [N*DW-1:0] beat_vec(input int base, input int b);
    logic [N*DW-1:0] v;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = DW'(base + b*16 + i);
    return v;
  endfunction

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b1; k_len = 16'd5; in_data = '1;
    @(negedge clk); @(negedge clk);
    checks++;
    if ({out_data, out_valid, out_first, out_last, busy, done, in_ready} !== '0) begin
      failures++;
      $display("FAIL reset_outputs data=%h v/f/l/busy/done/rdy=%b%b%b%b%b%b want all 0",
               out_data, out_valid, out_first, out_last, busy, done, in_ready);
    end
    rst_n = 1'b1; in_valid = 1'b0; in_data = '0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_release busy=%b in_ready=%b want 0 0", busy, in_ready);
    end
  endtask

  task automatic test_basic;
    logic [N*DW-1:0] exp_d;
    logic [3:0] exp_f;
    int b;
    start = 1'b1; k_len = 16'd4;
    @(negedge clk);
    start = 1'b0; k_len = 16'd9;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL basic_enter in_ready=%b busy=%b want 1 1", in_ready, busy);
    end
    for (int c = 0; c < 10; c++) begin
      in_valid = (c < 4);
      in_data  = (c < 4) ? beat_vec(0, c) : '0;
      @(negedge clk);
      exp_d = '0;
      for (int i = 0; i < N; i++) begin
        b = c - i;
        if (b >= 0 && b < 4) exp_d[i*DW +: DW] = DW'(b*16 + i);
      end
      exp_f = {c <= 6, c == 0, c == 6, c == 7};
      checks++;
      if (out_data !== exp_d) begin
        failures++;
        $display("FAIL basic_data cyc=%0d got=%h want=%h", c+1, out_data, exp_d);
      end
      checks++;
      if ({out_valid, out_first, out_last, done} !== exp_f) begin
        failures++;
        $display("FAIL basic_markers cyc=%0d v/f/l/d got=%b want=%b", c+1,
                 {out_valid, out_first, out_last, done}, exp_f);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_bubbles;
    int slot [4] = '{0, -1, 1, 2};
    logic [N*DW-1:0] exp_d;
    logic [3:0] exp_f;
    int s;
    start = 1'b1; k_len = 16'd3;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 10; c++) begin
      in_valid = (c < 4) && (slot[c < 4 ? c : 0] >= 0);
      in_data  = (c < 4 && slot[c < 4 ? c : 0] >= 0) ? beat_vec(16'h100, slot[c]) : beat_vec(16'h800, 9);
      @(negedge clk);
      exp_d = '0;
      for (int i = 0; i < N; i++) begin
        s = c - i;
        if (s >= 0 && s < 4 && slot[s] >= 0) exp_d[i*DW +: DW] = DW'(16'h100 + slot[s]*16 + i);
      end
      exp_f = {c <= 6, c == 0, c == 6, c == 7};
      checks++;
      if (out_data !== exp_d) begin
        failures++;
        $display("FAIL bubble_data cyc=%0d got=%h want=%h", c+1, out_data, exp_d);
      end
      checks++;
      if ({out_valid, out_first, out_last, done} !== exp_f) begin
        failures++;
        $display("FAIL bubble_markers cyc=%0d v/f/l/d got=%b want=%b", c+1,
                 {out_valid, out_first, out_last, done}, exp_f);
      end
    end
    in_valid = 1'b0; in_data = '0;
  endtask

  task automatic test_zero_len;
    start = 1'b1; k_len = 16'd0; in_valid = 1'b1;
    for (int o = 1; o <= 4; o++) begin
      @(negedge clk);
      start = 1'b0;
      checks++;
      if ({out_valid, out_first, out_last, in_ready} !== 4'b0000 || done !== (o == 2)) begin
        failures++;
        $display("FAIL zero_len cyc=%0d v/f/l/rdy=%b%b%b%b done=%b want 0000 done=%b",
                 o, out_valid, out_first, out_last, in_ready, done, o == 2);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_start_ignored;
    int acc = 0, dones = 0, last_c = -1;
    logic [DW-1:0] lane3_at_last = '0;
    start = 1'b1; k_len = 16'd4;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 14; c++) begin
      in_valid = 1'b1;
      in_data  = beat_vec(16'h200, c);
      start    = (c == 1);
      k_len    = (c == 1) ? 16'd9 : 16'd4;
      if (in_ready) acc++;
      @(negedge clk);
      if (done) dones++;
      if (out_last) begin
        last_c = c;
        lane3_at_last = out_data[3*DW +: DW];
      end
    end
    start = 1'b0; in_valid = 1'b0;
    checks++;
    if (acc !== 4) begin failures++; $display("FAIL ignore_accepts got=%0d want=4", acc); end
    checks++;
    if (dones !== 1) begin failures++; $display("FAIL ignore_dones got=%0d want=1", dones); end
    checks++;
    if (last_c !== 6) begin failures++; $display("FAIL ignore_last_cycle got=%0d want=6", last_c + 1); end
    checks++;
    if (lane3_at_last !== 16'h233) begin
      failures++;
      $display("FAIL ignore_last_data got=%h want=0233", lane3_at_last);
    end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL ignore_idle busy=%b want 0", busy); end
  endtask

  task automatic test_reset_flush;
    int dones = 0;
    logic [N*DW-1:0] exp_d;
    logic [3:0] exp_f;
    int b;
    start = 1'b1; k_len = 16'd2;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 2; c++) begin
      in_valid = 1'b1; in_data = beat_vec(16'h300, c);
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if (out_data[0 +: DW] !== 16'h310 || busy !== 1'b1) begin
      failures++;
      $display("FAIL rflush_pre lane0=%h busy=%b want 0310 1", out_data[0 +: DW], busy);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (out_data !== '0 || busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rflush_after data=%h busy=%b done=%b valid=%b want 0", out_data, busy, done, out_valid);
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done) dones++;
    end
    checks++;
    if (dones !== 0) begin failures++; $display("FAIL rflush_no_done got=%0d want=0", dones); end
    start = 1'b1; k_len = 16'd2;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 8; c++) begin
      in_valid = (c < 2);
      in_data  = (c < 2) ? beat_vec(16'h380, c) : '0;
      @(negedge clk);
      exp_d = '0;
      for (int i = 0; i < N; i++) begin
        b = c - i;
        if (b >= 0 && b < 2) exp_d[i*DW +: DW] = DW'(16'h380 + b*16 + i);
      end
      exp_f = {c <= 4, c == 0, c == 4, c == 5};
      checks++;
      if (out_data !== exp_d || {out_valid, out_first, out_last, done} !== exp_f) begin
        failures++;
        $display("FAIL rflush_tile cyc=%0d data=%h want=%h v/f/l/d=%b want=%b", c+1,
                 out_data, exp_d, {out_valid, out_first, out_last, done}, exp_f);
      end
    end
    in_valid = 1'b0;
  endtask

`ifdef OPERAND_SKEWER_LANE_MASK_EN
  task automatic test_lane_mask;
    logic [N*DW-1:0] exp_d;
    logic [3:0] exp_f;
    int b;
    lane_mask = 4'b0101; start = 1'b1; k_len = 16'd2;
    @(negedge clk);
    start = 1'b0; lane_mask = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      in_valid = (c < 2);
      in_data  = (c < 2) ? beat_vec(16'h400, c) : '0;
      @(negedge clk);
      exp_d = '0;
      for (int i = 0; i < N; i += 2) begin
        b = c - i;
        if (b >= 0 && b < 2) exp_d[i*DW +: DW] = DW'(16'h400 + b*16 + i);
      end
      exp_f = {c <= 4, c == 0, c == 4, c == 5};
      checks++;
      if (out_data !== exp_d || {out_valid, out_first, out_last, done} !== exp_f) begin
        failures++;
        $display("FAIL mask_tile cyc=%0d data=%h want=%h v/f/l/d=%b want=%b", c+1,
                 out_data, exp_d, {out_valid, out_first, out_last, done}, exp_f);
      end
    end
    in_valid = 1'b0;
  endtask
`endif

  initial begin
`ifdef OPERAND_SKEWER_LANE_MASK_EN
    lane_mask = 4'b1111;
`endif
    test_reset();
    test_basic();
    test_bubbles();
    test_zero_len();
    test_start_ignored();
    test_reset_flush();
`ifdef OPERAND_SKEWER_LANE_MASK_EN
    test_lane_mask();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
